// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous 4-bit ripple counter into the clk domain, accepts only
// settled values and extends them into a wider running total with wrap/step flags.

module rcs_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

module ripple_count_sampler #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int EXT_WIDTH     = 12,
    parameter int MAX_STEP      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cnt_in,
    output logic [3:0]           count_out,
    output logic [EXT_WIDTH-1:0] ext_count,
    output logic [3:0]           delta,
    output logic                 upd,
    output logic                 wrap,
    output logic                 step_err
);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STAB_MIN = SCW'(STABLE_CYCLES - 1);
    localparam logic [3:0]     STEP_LIM = 4'(MAX_STEP);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [3:0]             s;
    logic [3:0]             s_prev;
    logic [SCW-1:0]         stab;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic [0:0]             state;
    logic                   same;
    logic                   settled;
    logic                   accept;
    logic [3:0]             d;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        rcs_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (cnt_in[i]),
            .q   (s[i])
        );
    end

    // The zeros flushed into the chains by reset are not real samples: s only
    // counts once the chain has been refilled, and s_prev one edge later.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end

    assign same    = vld_pipe[SYNC_STAGES] && (s == s_prev);
    assign settled = same && (stab >= STAB_MIN);
    assign d       = s - count_out;
    assign accept  = (state == ST_TRACK) && settled && (s != count_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev <= '0;
            stab   <= '0;
        end else begin
            s_prev <= s;
            if (!same)                stab <= '0;
            else if (stab != STAB_MAX) stab <= stab + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            count_out <= '0;
            ext_count <= '0;
            delta     <= '0;
            upd       <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            upd  <= 1'b0;
            wrap <= 1'b0;
            if (state == ST_INIT) begin
                if (settled) begin
                    count_out <= s;
                    state     <= ST_TRACK;
                end
            end else if (accept) begin
                count_out <= s;
                delta     <= d;
                ext_count <= ext_count + {{(EXT_WIDTH-4){1'b0}}, d};
                upd       <= 1'b1;
                wrap      <= (s < count_out);
                if (d > STEP_LIM) step_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Randomized/directed bench for ripple_count_sampler with a sample-history
// reference model feeding a scoreboard that the monitor drains on each upd.

module tb_ripple_count_sampler;
    localparam int SYNC = 2, STAB = 2, EW = 12, MAXS = 4;
    localparam int W = SYNC + STAB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    cnt_in = 4'd5;
    logic [3:0]    count_out, delta;
    logic [EW-1:0] ext_count;
    logic          upd, wrap, step_err;

    ripple_count_sampler #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .EXT_WIDTH(EW), .MAX_STEP(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .count_out(count_out),
        .ext_count(ext_count), .delta(delta), .upd(upd), .wrap(wrap), .step_err(step_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    cnt;
        logic [3:0]    dlt;
        logic [EW-1:0] ext;
        logic          wr;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0;
    int   upd_cnt = 0, wrap_cnt = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keep the last W raw samples; s at an edge is the sample
    // taken SYNC edges earlier, settled when STAB+1 consecutive s are equal.
    logic [3:0] hist[$];
    bit         m_init, m_err, m_upd;
    logic [3:0] m_count;
    int         m_ext;

    always @(posedge clk) begin
        bit         eq;
        logic [3:0] v, dd;
        exp_t       e;
        m_upd = 0;
        if (rst) begin
            hist.delete();
            m_init = 1; m_count = 0; m_ext = 0; m_err = 0;
        end else begin
            hist.push_back(cnt_in);
            if (hist.size() > W) void'(hist.pop_front());
            if (hist.size() == W) begin
                v  = hist[STAB];
                eq = 1;
                for (int j = 0; j < STAB; j++) if (hist[j] != v) eq = 0;
                if (eq) begin
                    if (m_init) begin
                        m_count = v;
                        m_init  = 0;
                    end else if (v != m_count) begin
                        dd    = 4'((int'(v) - int'(m_count) + 16) % 16);
                        m_ext = (m_ext + int'(dd)) % (1 << EW);
                        if (int'(dd) > MAXS) m_err = 1;
                        e.cnt = v; e.dlt = dd; e.ext = EW'(m_ext);
                        e.wr  = (v < m_count); e.err = m_err;
                        sb.push_back(e);
                        m_count = v;
                        m_upd   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("count_out_cycle", count_out, m_count);
            chk("upd_cycle", upd, m_upd);
            if (upd === 1'b1) begin
                upd_cnt++;
                if (wrap === 1'b1) wrap_cnt++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL upd_unexpected: upd with empty scoreboard at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_count", count_out, e.cnt);
                    chk("sb_delta", delta, e.dlt);
                    chk("sb_ext", ext_count, e.ext);
                    chk("sb_wrap", wrap, e.wr);
                    chk("sb_step_err", step_err, e.err);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] v, input int n);
        cnt_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, count_out, 0);
        chk({tag, "_ext"}, ext_count, 0);
        chk({tag, "_delta"}, delta, 0);
        chk({tag, "_upd"}, upd, 0);
        chk({tag, "_wrap"}, wrap, 0);
        chk({tag, "_step_err"}, step_err, 0);
    endtask

    initial begin
        int u0, w0, rem, step, guard;
        @(posedge clk);
        mon_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        rst = 0;
        u0 = upd_cnt;
        drive(4'd5, 8);
        chk("init_count", count_out, 5);
        chk("init_ext", ext_count, 0);
        chk("init_no_upd", upd_cnt, u0);

        drive(4'd9, 6); drive(4'd13, 6); drive(4'd0, 6);
        drive(4'd1, 6);
        chk("single_count", count_out, 1);
        chk("single_delta", delta, 1);
        chk("single_wrap", wrap, 0);

        drive(4'd5, 6); drive(4'd7, 6);
        u0 = upd_cnt;
        drive(4'd6, 1); drive(4'd4, 1); drive(4'd0, 1); drive(4'd8, 8);
        chk("glitch_one_upd", upd_cnt - u0, 1);
        chk("glitch_count", count_out, 8);
        chk("glitch_delta", delta, 1);
        chk("glitch_step_err", step_err, 0);

        drive(4'd12, 6); drive(4'd15, 6);
        w0 = wrap_cnt;
        drive(4'd0, 6);
        chk("wrap_pulse", wrap_cnt - w0, 1);
        chk("wrap_delta", delta, 1);

        drive(4'd3, 6); drive(4'd9, 6);
        chk("skip_delta", delta, 6);
        chk("skip_step_err", step_err, 1);
        drive(4'd10, 6); drive(4'd12, 6);
        chk("sticky_step_err", step_err, 1);

        guard = 0;
        while (m_ext != 4094 && guard < 2000) begin
            rem  = (4094 - m_ext + 4096) % 4096;
            step = (rem > 4) ? 4 : rem;
            drive(4'((int'(m_count) + step) % 16), 6);
            guard++;
        end
        chk("preload_ext", ext_count, 4094);
        drive(4'((int'(m_count) + 1) % 16), 6);
        drive(4'((int'(m_count) + 1) % 16), 6);
        chk("ext_wrap_zero", ext_count, 0);

        cnt_in = 4'((int'(m_count) + 1) % 16);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst = 0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1, 0) == 1)
                drive(4'((int'(m_count) + $urandom_range(4, 1)) % 16), $urandom_range(7, 1));
            else
                drive(4'($urandom_range(15, 0)), $urandom_range(7, 1));
        end
        drive(cnt_in, 8);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
